// File: rtl/replay_pkg.sv
// Shared definitions for the replay buffer sampling path.
package replay_pkg;

    // Default widths for the LFSR and the replay memory address.
    localparam int NBITS_DEF  = 16;
    localparam int ADDR_W_DEF = 10;

    // An all-zero LFSR state locks up, so a zero seed is replaced by this value.
    localparam int LFSR_NONZERO_SEED = 1;

    // Sampler FSM states.
    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_SEED  = 3'd1,
        S_DRAW  = 3'd2,
        S_OFFER = 3'd3,
        S_DONE  = 3'd4
    } state_t;

endpackage

// File: rtl/replay_sampler.sv
// Replay sampler: seeds the external LFSR, rejection-maps its state into
// [0, fill) and issues batch_len read addresses over a valid/ready handshake.
// After too many consecutive rejects, a round-robin fallback index is used instead.
module replay_sampler
    import replay_pkg::*;
#(
    parameter int NBITS     = NBITS_DEF,
    parameter int ADDR_W    = ADDR_W_DEF,
    parameter int REJ_LIMIT = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              reseed,
    input  logic [NBITS-1:0]  seed,
    input  logic [7:0]        batch_len,
    input  logic [ADDR_W:0]   fill_count,
    output logic              lfsr_we,
    output logic [NBITS-1:0]  lfsr_data,
    input  logic [NBITS-2:0]  lfsr_q,
    input  logic              lfsr_fin,
    output logic              rd_valid,
    input  logic              rd_ready,
    output logic [ADDR_W-1:0] rd_addr,
    output logic              busy,
    output logic              done,
    output logic              err_empty,
    output logic              fallback,
    output logic [7:0]        wraps
);

    localparam int REJ_W = $clog2(REJ_LIMIT) + 1;

    state_t              state_q, state_d;
    logic [ADDR_W:0]     fill_q, fill_d;
    logic [7:0]          len_q, len_d;
    logic [7:0]          sent_q, sent_d;
    logic [NBITS-1:0]    seed_q, seed_d;
    logic [REJ_W-1:0]    rej_q, rej_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [ADDR_W-1:0]   fb_q, fb_d;
    logic                err_q, err_d;
    logic                fallback_q, fallback_d;
    logic [7:0]          wraps_q, wraps_d;
    logic                fin_prev_q, fin_prev_d;

    logic [ADDR_W:0]     cand;
    logic [ADDR_W-1:0]   fb_base;
    logic [ADDR_W:0]     fb_inc;
    logic [ADDR_W-1:0]   fb_next;
    logic [8:0]          sent_inc;

    // Only the low ADDR_W bits of the LFSR state form a candidate index.
    generate
        if (ADDR_W < NBITS - 1) begin : g_upper
            logic unused_upper;
            assign unused_upper = ^lfsr_q[NBITS-2:ADDR_W];
        end
    endgenerate

    // Next-state logic: FSM transitions, rejection mapping, fallback pointer and wrap counting.
    always_comb begin
        state_d    = state_q;
        fill_d     = fill_q;
        len_d      = len_q;
        sent_d     = sent_q;
        seed_d     = seed_q;
        rej_d      = rej_q;
        addr_d     = addr_q;
        fb_d       = fb_q;
        err_d      = 1'b0;
        fallback_d = 1'b0;
        wraps_d    = wraps_q;
        fin_prev_d = lfsr_fin;

        cand     = {1'b0, lfsr_q[ADDR_W-1:0]};
        // A pointer left over from a larger earlier fill restarts at 0 so it stays in range.
        fb_base  = ({1'b0, fb_q} < fill_q) ? fb_q : '0;
        fb_inc   = {1'b0, fb_base} + {{ADDR_W{1'b0}}, 1'b1};
        fb_next  = (fb_inc == fill_q) ? '0 : fb_inc[ADDR_W-1:0];
        sent_inc = {1'b0, sent_q} + 9'd1;

        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    if (fill_count == '0) begin
                        err_d = 1'b1;
                    end else begin
                        fill_d = fill_count;
                        len_d  = batch_len;
                        seed_d = seed;
                        rej_d  = '0;
                        sent_d = '0;
                        if (batch_len == 8'd0) begin
                            state_d = S_DONE;
                        end else if (reseed) begin
                            state_d = S_SEED;
                        end else begin
                            state_d = S_DRAW;
                        end
                    end
                end
            end
            S_SEED: begin
                state_d = S_DRAW;
            end
            S_DRAW: begin
                if (cand < fill_q) begin
                    addr_d  = cand[ADDR_W-1:0];
                    rej_d   = '0;
                    state_d = S_OFFER;
                end else if (rej_q == REJ_W'(REJ_LIMIT - 1)) begin
                    addr_d     = fb_base;
                    fb_d       = fb_next;
                    fallback_d = 1'b1;
                    rej_d      = '0;
                    state_d    = S_OFFER;
                end else begin
                    rej_d = rej_q + REJ_W'(1);
                end
            end
            S_OFFER: begin
                if (rd_ready) begin
                    sent_d = sent_inc[7:0];
                    if (sent_inc == {1'b0, len_q}) begin
                        state_d = S_DONE;
                    end else begin
                        state_d = S_DRAW;
                    end
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        if ((state_q != S_IDLE) && lfsr_fin && !fin_prev_q && (wraps_q != 8'hFF)) begin
            wraps_d = wraps_q + 8'd1;
        end
    end

    // State and datapath registers; async reset returns everything to a clean idle.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= S_IDLE;
            fill_q     <= '0;
            len_q      <= '0;
            sent_q     <= '0;
            seed_q     <= '0;
            rej_q      <= '0;
            addr_q     <= '0;
            fb_q       <= '0;
            err_q      <= 1'b0;
            fallback_q <= 1'b0;
            wraps_q    <= '0;
            fin_prev_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            fill_q     <= fill_d;
            len_q      <= len_d;
            sent_q     <= sent_d;
            seed_q     <= seed_d;
            rej_q      <= rej_d;
            addr_q     <= addr_d;
            fb_q       <= fb_d;
            err_q      <= err_d;
            fallback_q <= fallback_d;
            wraps_q    <= wraps_d;
            fin_prev_q <= fin_prev_d;
        end
    end

    // Outputs decode directly from the state register so reset clears them immediately.
    always_comb begin
        busy      = (state_q != S_IDLE);
        rd_valid  = (state_q == S_OFFER);
        done      = (state_q == S_DONE);
        lfsr_we   = (state_q == S_SEED);
        lfsr_data = '0;
        if (state_q == S_SEED) begin
            lfsr_data = (seed_q == '0) ? NBITS'(LFSR_NONZERO_SEED) : seed_q;
        end
        rd_addr   = addr_q;
        err_empty = err_q;
        fallback  = fallback_q;
        wraps     = wraps_q;
    end

endmodule

// File: tb/tb_replay_sampler.sv
// Directed testbench for replay_sampler with a behavioural stand-in for the LFSR.
module tb_replay_sampler;

    logic        clk;
    logic        rst;
    logic        start;
    logic        reseed;
    logic [15:0] seed;
    logic [7:0]  batch_len;
    logic [10:0] fill_count;
    logic        lfsr_we;
    logic [15:0] lfsr_data;
    logic [14:0] lfsr_q;
    logic        lfsr_fin;
    logic        rd_valid;
    logic        rd_ready;
    logic [9:0]  rd_addr;
    logic        busy;
    logic        done;
    logic        err_empty;
    logic        fallback;
    logic [7:0]  wraps;

    logic [14:0] model_q;
    logic        force_en;
    logic [14:0] force_val;

    int checks;
    int failures;

    typedef struct {
        logic [14:0] q;
        logic [10:0] fill;
        logic [9:0]  exp_addr;
        logic        exp_fb;
        int          exp_lat;
    } vec_t;

    vec_t vecs[8];

    replay_sampler #(.NBITS(16), .ADDR_W(10), .REJ_LIMIT(8)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .reseed     (reseed),
        .seed       (seed),
        .batch_len  (batch_len),
        .fill_count (fill_count),
        .lfsr_we    (lfsr_we),
        .lfsr_data  (lfsr_data),
        .lfsr_q     (lfsr_q),
        .lfsr_fin   (lfsr_fin),
        .rd_valid   (rd_valid),
        .rd_ready   (rd_ready),
        .rd_addr    (rd_addr),
        .busy       (busy),
        .done       (done),
        .err_empty  (err_empty),
        .fallback   (fallback),
        .wraps      (wraps)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Stand-in LFSR: loads on we, otherwise shifts left with x^15+x^14 feedback.
    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            model_q <= 15'h0001;
        end else if (lfsr_we) begin
            model_q <= lfsr_data[14:0];
        end else begin
            model_q <= {model_q[13:0], model_q[14] ^ model_q[13]};
        end
    end

    assign lfsr_q = force_en ? force_val : model_q;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic apply_stimulus(input logic rs, input logic [15:0] sd,
                                  input logic [7:0] len, input logic [10:0] fill);
        reseed     = rs;
        seed       = sd;
        batch_len  = len;
        fill_count = fill;
        start      = 1'b1;
        tick();
        start      = 1'b0;
    endtask

    task automatic wait_valid(input int limit, output int lat);
        lat = 1;
        while (!rd_valid && lat < limit) begin
            tick();
            lat++;
        end
    endtask

    task automatic drain(input int limit);
        int n;
        n = 0;
        while (busy && n < limit) begin
            tick();
            n++;
        end
        check_output("drain_idle", busy, 1'b0);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int lat;
        int cyc;
        int k;
        int first_lat;
        int last_valid;
        int done_cyc;
        int fb_cnt;
        int bad;
        int got[4];

        checks     = 0;
        failures   = 0;
        rst        = 1'b0;
        start      = 1'b0;
        reseed     = 1'b0;
        seed       = '0;
        batch_len  = '0;
        fill_count = '0;
        lfsr_fin   = 1'b0;
        rd_ready   = 1'b0;
        force_en   = 1'b0;
        force_val  = '0;

        vecs[0] = '{15'd5,      11'd1024, 10'd5,   1'b0, 2};
        vecs[1] = '{15'h03FF,   11'd1024, 10'd1023, 1'b0, 2};
        vecs[2] = '{15'd9,      11'd10,   10'd9,   1'b0, 2};
        vecs[3] = '{15'd10,     11'd10,   10'd0,   1'b1, 9};
        vecs[4] = '{15'h7ABC,   11'd700,  10'd1,   1'b1, 9};
        vecs[5] = '{15'h4005,   11'd6,    10'd5,   1'b0, 2};
        vecs[6] = '{15'd20,     11'd3,    10'd2,   1'b1, 9};
        vecs[7] = '{15'd100,    11'd3,    10'd0,   1'b1, 9};

        #12;
        check_output("rst_busy",     busy,      1'b0);
        check_output("rst_rd_valid", rd_valid,  1'b0);
        check_output("rst_done",     done,      1'b0);
        check_output("rst_lfsr_we",  lfsr_we,   1'b0);
        check_output("rst_wraps",    wraps,     8'd0);
        check_output("rst_rd_addr",  rd_addr,   10'd0);
        #10;
        rst = 1'b1;
        tick();

        // Empty replay memory.
        apply_stimulus(1'b0, 16'h0, 8'd4, 11'd0);
        check_output("empty_err",      err_empty, 1'b1);
        check_output("empty_busy",     busy,      1'b0);
        check_output("empty_rd_valid", rd_valid,  1'b0);
        tick();
        check_output("empty_err_pulse", err_empty, 1'b0);
        check_output("empty_rd_valid2", rd_valid,  1'b0);

        // Zero-length batch goes straight to DONE.
        apply_stimulus(1'b0, 16'h0, 8'd0, 11'd1024);
        check_output("len0_done",     done,     1'b1);
        check_output("len0_rd_valid", rd_valid, 1'b0);
        tick();
        check_output("len0_done_pulse", done, 1'b0);
        check_output("len0_idle",       busy, 1'b0);

        // Reseed with 0x0001, four addresses from successive LFSR states.
        rd_ready = 1'b1;
        apply_stimulus(1'b1, 16'h0001, 8'd4, 11'd1024);
        check_output("seed1_we",   lfsr_we,   1'b1);
        check_output("seed1_data", lfsr_data, 16'h0001);
        tick();
        check_output("seed1_we_once", lfsr_we, 1'b0);
        cyc = 2;
        k = 0;
        first_lat = 0;
        last_valid = 0;
        done_cyc = 0;
        while (!done && cyc < 40) begin
            tick();
            cyc++;
            if (rd_valid) begin
                if (k == 0) first_lat = cyc;
                if (k < 4) got[k] = rd_addr;
                last_valid = cyc;
                k++;
            end
            if (done) done_cyc = cyc;
        end
        check_output("seed1_latency", first_lat, 3);
        check_output("seed1_count",   k,         4);
        check_output("seed1_addr0",   got[0],    1);
        check_output("seed1_addr1",   got[1],    4);
        check_output("seed1_addr2",   got[2],    16);
        check_output("seed1_addr3",   got[3],    64);
        check_output("seed1_done_after_last", done_cyc, last_valid + 1);
        tick();
        check_output("seed1_done_pulse", done, 1'b0);

        // Zero seed is replaced to avoid LFSR lock-up.
        apply_stimulus(1'b1, 16'h0000, 8'd1, 11'd1024);
        check_output("seed0_we",   lfsr_we,   1'b1);
        check_output("seed0_data", lfsr_data, 16'h0001);
        drain(20);

        // Single-address batches with a held LFSR state.
        force_en = 1'b1;
        for (int i = 0; i < 8; i++) begin
            force_val = vecs[i].q;
            apply_stimulus(1'b0, 16'h0, 8'd1, vecs[i].fill);
            wait_valid(20, lat);
            check_output($sformatf("vec%0d_valid", i),    rd_valid, 1'b1);
            check_output($sformatf("vec%0d_latency", i),  lat,      vecs[i].exp_lat);
            check_output($sformatf("vec%0d_addr", i),     rd_addr,  vecs[i].exp_addr);
            check_output($sformatf("vec%0d_fallback", i), fallback, vecs[i].exp_fb);
            tick();
            check_output($sformatf("vec%0d_done", i), done, 1'b1);
            tick();
            check_output($sformatf("vec%0d_idle", i), busy, 1'b0);
        end

        // Back-pressure in OFFER, ignored start, and wrap counting.
        lfsr_fin = 1'b1;
        tick();
        lfsr_fin = 1'b0;
        tick();
        check_output("wraps_idle_ignored", wraps, 8'd0);
        rd_ready  = 1'b0;
        force_val = 15'h0155;
        apply_stimulus(1'b0, 16'h0, 8'd1, 11'd1024);
        wait_valid(20, lat);
        check_output("stall_valid", rd_valid, 1'b1);
        check_output("stall_addr",  rd_addr,  10'h155);
        for (int i = 0; i < 5; i++) begin
            lfsr_fin   = (i % 2 == 0);
            fill_count = 11'd0;
            start      = 1'b1;
            tick();
            check_output($sformatf("stall%0d_valid", i), rd_valid,  1'b1);
            check_output($sformatf("stall%0d_addr", i),  rd_addr,   10'h155);
            check_output($sformatf("stall%0d_err", i),   err_empty, 1'b0);
        end
        start    = 1'b0;
        lfsr_fin = 1'b0;
        check_output("wraps_three", wraps, 8'd3);
        for (int i = 0; i < 300; i++) begin
            lfsr_fin = 1'b1;
            tick();
            lfsr_fin = 1'b0;
            tick();
        end
        check_output("wraps_saturate", wraps, 8'd255);
        check_output("stall_still_valid", rd_valid, 1'b1);
        rd_ready = 1'b1;
        tick();
        check_output("stall_done", done, 1'b1);
        tick();

        // Reset in the middle of a batch.
        rd_ready  = 1'b0;
        force_val = 15'd7;
        apply_stimulus(1'b0, 16'h0, 8'd4, 11'd1024);
        wait_valid(20, lat);
        #2;
        rst = 1'b0;
        #1;
        check_output("midrst_rd_valid", rd_valid, 1'b0);
        check_output("midrst_busy",     busy,     1'b0);
        check_output("midrst_done",     done,     1'b0);
        check_output("midrst_wraps",    wraps,    8'd0);
        #2;
        rst = 1'b1;
        tick();
        rd_ready = 1'b1;
        apply_stimulus(1'b0, 16'h0, 8'd1, 11'd1024);
        wait_valid(20, lat);
        check_output("fresh_latency", lat,     2);
        check_output("fresh_addr",    rd_addr, 10'd7);
        tick();
        check_output("fresh_done", done, 1'b1);
        tick();

        // Forced rejects: fallback walks 0,1,2,0.
        force_val = 15'h03FF;
        apply_stimulus(1'b0, 16'h0, 8'd4, 11'd3);
        cyc = 1;
        k = 0;
        fb_cnt = 0;
        while (!done && cyc < 100) begin
            tick();
            cyc++;
            if (rd_valid) begin
                if (k < 4) got[k] = rd_addr;
                k++;
            end
            if (fallback) fb_cnt++;
        end
        check_output("rej_done",     done,   1'b1);
        check_output("rej_count",    k,      4);
        check_output("rej_fb_count", fb_cnt, 4);
        check_output("rej_addr0",    got[0], 0);
        check_output("rej_addr1",    got[1], 1);
        check_output("rej_addr2",    got[2], 2);
        check_output("rej_addr3",    got[3], 0);
        tick();

        // Free-running LFSR with a tiny fill: every address must be in range.
        force_en = 1'b0;
        apply_stimulus(1'b0, 16'h0, 8'd16, 11'd3);
        cyc = 1;
        k = 0;
        bad = 0;
        while (!done && cyc < 400) begin
            tick();
            cyc++;
            if (rd_valid) begin
                k++;
                if (rd_addr >= 10'd3) bad++;
            end
        end
        check_output("fill3_done",     done, 1'b1);
        check_output("fill3_count",    k,    16);
        check_output("fill3_in_range", bad,  0);
        tick();
        check_output("fill3_idle", busy, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
